// File: rtl/inv_pkg.sv
// Shared definitions for the fraction-free Gauss-Jordan inversion sequencer.
//   N_DEF / W_DEF   : default matrix order and element width
//   RW_DEF / CW_DEF : row / column index widths for the N x 2N augmented array
//   elem_t          : one matrix element (arithmetic wraps modulo 2^W)
//   state_t         : sequencer states
package inv_pkg;

  localparam int N_DEF  = 5;
  localparam int W_DEF  = 8;
  localparam int RW_DEF = $clog2(N_DEF);
  localparam int CW_DEF = $clog2(2 * N_DEF);

  typedef logic [W_DEF-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PIV_CHK,
    SEARCH,
    SWAP,
    ROW_SETUP,
    ELIM,
    DONE
  } state_t;

endpackage

// File: rtl/inv_xmul.sv
// Shared cross-multiply element for row elimination.
//   a, b, c, d : W-bit operands
//   y          : (a*b - c*d) truncated to W bits
module inv_xmul
  import inv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);

  assign y = (a * b) - (c * d);

endmodule

// File: rtl/inv_gj_sequencer.sv
// Fraction-free Gauss-Jordan inversion controller plus N x 2N augmented array.
// The host loads the left half, pulses start, and the sequencer runs pivot
// check, pivot search with row swap, and row elimination one element per
// cycle. At completion the left half is diagonal and the right half holds the
// row-scaled inverse.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   wr_en/wr_row/wr_col/wr_data : host write into the left half (when not busy)
//   start                     : run request, accepted in IDLE only
//   rd_row/rd_col/rd_data     : registered readout, one cycle latency
//   busy, done, singular      : status
//   cyc_count                 : busy-cycle counter, present only when
//                               INV_PERF_CNT_EN is defined
module inv_gj_sequencer
  import inv_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [W-1:0]           wr_data,
  input  logic                   start,
  input  logic [$clog2(N)-1:0]   rd_row,
  input  logic [$clog2(2*N)-1:0] rd_col,
  output logic [W-1:0]           rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   singular
`ifdef INV_PERF_CNT_EN
  ,
  output logic [15:0]            cyc_count
`endif
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 1);

  state_t         state_reg;
  logic [RW-1:0]  p_reg, r_reg, s_reg;
  logic [CW-1:0]  c_reg;
  logic [W-1:0]   piv_reg, f_reg;
  logic [W-1:0]   mat [N][2*N];
  logic [W-1:0]   elim_val;

  // Next elimination row: step by one, hopping over the pivot row. One extra
  // bit so that running past the last row is visible.
  logic [RW:0]    r_inc, r_adv;
  logic           r_last;
  logic [RW-1:0]  r_first;

  always_comb begin
    r_inc  = {1'b0, r_reg} + (RW+1)'(1);
    r_adv  = r_inc;
    if (r_inc == {1'b0, p_reg}) r_adv = r_inc + (RW+1)'(1);
    r_last = (r_adv >= (RW+1)'(N));
  end

  assign r_first = (p_reg == '0) ? RW'(1) : '0;

  inv_xmul #(.W(W)) u_xmul (
    .a (mat[r_reg][c_reg]),
    .b (piv_reg),
    .c (f_reg),
    .d (mat[p_reg][c_reg]),
    .y (elim_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
      p_reg     <= '0;
      r_reg     <= '0;
      s_reg     <= '0;
      c_reg     <= '0;
      piv_reg   <= '0;
      f_reg     <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < 2 * N; j++)
          mat[i][j] <= '0;
    end else begin
      done <= 1'b0;
      if (wr_en && !busy && (int'(wr_row) < N) && (int'(wr_col) < N))
        mat[wr_row][wr_col] <= wr_data;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= INIT;
            busy      <= 1'b1;
            singular  <= 1'b0;
          end
        end
        INIT: begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              mat[i][N+j] <= (i == j) ? W'(1) : '0;
          p_reg     <= '0;
          state_reg <= PIV_CHK;
        end
        PIV_CHK: begin
          piv_reg <= mat[p_reg][p_reg];
          if (mat[p_reg][p_reg] != '0) begin
            r_reg     <= r_first;
            state_reg <= ROW_SETUP;
          end else if (p_reg == LAST_ROW) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            singular  <= 1'b1;
          end else begin
            s_reg     <= p_reg + RW'(1);
            state_reg <= SEARCH;
          end
        end
        SEARCH: begin
          if (mat[s_reg][p_reg] != '0) begin
            c_reg     <= '0;
            state_reg <= SWAP;
          end else if (s_reg == LAST_ROW) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            singular  <= 1'b1;
          end else begin
            s_reg <= s_reg + RW'(1);
          end
        end
        SWAP: begin
          mat[p_reg][c_reg] <= mat[s_reg][c_reg];
          mat[s_reg][c_reg] <= mat[p_reg][c_reg];
          if (c_reg == LAST_COL) begin
            c_reg     <= '0;
            state_reg <= PIV_CHK;
          end else begin
            c_reg <= c_reg + CW'(1);
          end
        end
        ROW_SETUP: begin
          f_reg     <= mat[r_reg][p_reg];
          c_reg     <= '0;
          state_reg <= ELIM;
        end
        ELIM: begin
          // Rows with f=0 still pass through here and get scaled by piv.
          mat[r_reg][c_reg] <= elim_val;
          if (c_reg == LAST_COL) begin
            c_reg <= '0;
            if (!r_last) begin
              r_reg     <= r_adv[RW-1:0];
              state_reg <= ROW_SETUP;
            end else if (p_reg == LAST_ROW) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              p_reg     <= p_reg + RW'(1);
              state_reg <= PIV_CHK;
            end
          end else begin
            c_reg <= c_reg + CW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else if ((int'(rd_row) < N) && (int'(rd_col) < 2 * N))
      rd_data <= mat[rd_row][rd_col];
    else
      rd_data <= '0;
  end

`ifdef INV_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc_count <= '0;
    else if (state_reg == IDLE && start)
      cyc_count <= '0;
    else if (busy && cyc_count != 16'hFFFF)
      cyc_count <= cyc_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_inv_gj_sequencer.sv
// Self-checking bench for inv_gj_sequencer: a table of directed matrices with
// constant expected cycle counts / singular flags, randomized matrices, and
// hand-written sequences for mid-run disturbance and mid-run reset. Array
// contents are checked against a loop-level Gauss-Jordan reference model.
// Build with INV_PERF_CNT_EN defined to also check cyc_count.
module tb_inv_gj_sequencer;

  localparam int N = 5;
  localparam int W = 8;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef struct {
    mat_t a;
    int   exp_busy;
    int   exp_sing;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_row = '0;
  logic [2:0]    wr_col = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [2:0]    rd_row = '0;
  logic [3:0]    rd_col = '0;
  inv_pkg::elem_t rd_data;
  logic          busy, done, singular;
`ifdef INV_PERF_CNT_EN
  logic [15:0]   cyc_count;
`endif

  inv_gj_sequencer #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .start    (start),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .singular (singular)
`ifdef INV_PERF_CNT_EN
    ,
    .cyc_count(cyc_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int run_id = 0;

  // Reference model state
  int mm [N][2*N];
  int m_cycles;
  int m_sing;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Fraction-free Gauss-Jordan on plain integers, with the busy-cycle cost
  // of each phase tallied alongside.
  function automatic void model(input mat_t a);
    int found, piv, f, tmp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2 * N; j++)
        mm[i][j] = (j < N) ? int'(a[i][j]) : ((j - N == i) ? 1 : 0);
    m_cycles = 1;
    m_sing = 0;
    for (int p = 0; p < N; p++) begin
      m_cycles++;
      if (mm[p][p] == 0) begin
        found = -1;
        for (int s = p + 1; s < N && found < 0; s++) begin
          m_cycles++;
          if (mm[s][p] != 0) found = s;
        end
        if (found < 0) begin
          m_sing = 1;
          break;
        end
        for (int c = 0; c < 2 * N; c++) begin
          tmp = mm[p][c];
          mm[p][c] = mm[found][c];
          mm[found][c] = tmp;
        end
        m_cycles += 2 * N + 1;
      end
      piv = mm[p][p];
      for (int r = 0; r < N; r++) begin
        if (r != p) begin
          f = mm[r][p];
          for (int c = 0; c < 2 * N; c++)
            mm[r][c] = (mm[r][c] * piv - f * mm[p][c]) & ((1 << W) - 1);
          m_cycles += 2 * N + 1;
        end
      end
    end
  endfunction

  task automatic load(input mat_t a);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        @(negedge clk);
        wr_en   = 1'b1;
        wr_row  = 3'(i);
        wr_col  = 3'(j);
        wr_data = a[i][j];
      end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2 * N; j++) begin
        @(negedge clk);
        rd_row = 3'(i);
        rd_col = 4'(j);
        @(negedge clk);
        chk($sformatf("mat[%0d][%0d]", i, j), int'(rd_data), mm[i][j]);
      end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // exp_busy / exp_sing < 0 mean "no constant expectation, model only".
  task automatic run(input mat_t a, input int exp_busy, input int exp_sing, input bit disturb);
    int nb;
    bit got_done;
    model(a);
    load(a);
    pulse_start();
    chk("singular_cleared", int'(singular), 0);
    nb = 0;
    got_done = 0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        got_done = 1;
        chk("busy_at_done", int'(busy), 0);
      end else if (busy) begin
        nb++;
      end
      if (disturb) begin
        if (k >= 20 && k < 30) begin
          wr_en   = 1'b1;
          wr_row  = 3'($urandom_range(0, N - 1));
          wr_col  = 3'($urandom_range(0, N - 1));
          wr_data = 8'($urandom_range(0, 255));
          start   = 1'b1;
        end else begin
          wr_en = 1'b0;
          start = 1'b0;
        end
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("done_seen", int'(got_done), 1);
    chk("busy_cycles_model", nb, m_cycles);
    if (exp_busy >= 0) chk("busy_cycles", nb, exp_busy);
    chk("singular_model", int'(singular), m_sing);
    if (exp_sing >= 0) chk("singular", int'(singular), exp_sing);
    $display("run %0d: busy_cycles=%0d singular=%0d", run_id, nb, singular);
    run_id++;
`ifdef INV_PERF_CNT_EN
    chk("cyc_count", int'(cyc_count), m_cycles);
`endif
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    readback();
`ifdef INV_PERF_CNT_EN
    chk("cyc_count_hold", int'(cyc_count), m_cycles);
`endif
  endtask

  initial begin
    mat_t ra;

    // Directed table: identity, row swap, singular column 0, wrap to zero.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vecs[0].a[i][j] = (i == j) ? 8'd1 : 8'd0;
        vecs[1].a[i][j] = (((i == 0 && j == 1) || (i == 1 && j == 0) || (i > 1 && i == j))) ? 8'd1 : 8'd0;
        vecs[2].a[i][j] = (j == 0) ? 8'd0 : 8'(i + j);
        vecs[3].a[i][j] = (i == j) ? ((i < 2) ? 8'd16 : 8'd1) : 8'd0;
      end
    vecs[0].exp_busy = 226; vecs[0].exp_sing = 0;
    vecs[1].exp_busy = 238; vecs[1].exp_sing = 0;
    vecs[2].exp_busy = 6;   vecs[2].exp_sing = 1;
    vecs[3].exp_busy = 50;  vecs[3].exp_sing = 1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_singular", int'(singular), 0);
    chk("rst_rd_data", int'(rd_data), 0);
`ifdef INV_PERF_CNT_EN
    chk("rst_cyc_count", int'(cyc_count), 0);
`endif

    for (int t = 0; t < 4; t++) begin
      run(vecs[t].a, vecs[t].exp_busy, vecs[t].exp_sing, 1'b0);
      if (t == 2) begin
        repeat (5) @(negedge clk);
        chk("singular_hold", int'(singular), 1);
      end
    end

    // Randomized matrices, occasionally zero-heavy to provoke swaps/singular.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          ra[i][j] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (t % 2 == 0) ra[0][0] = 8'd0;
      run(ra, -1, -1, 1'b0);
    end

    // Host writes and start pulses during a run must not disturb the result.
    run(vecs[1].a, 238, 0, 1'b1);

    // Reset in the middle of a run.
    load(vecs[0].a);
    pulse_start();
    repeat (99) @(negedge clk);
    chk("busy_before_abort", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2 * N; j++)
        mm[i][j] = 0;
    readback();
    chk("abort_singular", int'(singular), 0);
    run(vecs[0].a, 226, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_gj_sequencer.md
Name: inv_gj_sequencer

Overview:
Controller plus storage for fraction-free Gauss-Jordan inversion of an N x N matrix held as an N x 2N augmented array, with identity in the right half. It loads the left half from a host, then sequences pivot check, pivot search with row swap, and row elimination using a single shared cross-multiply element, one element per cycle. At completion the left half is diagonal and the right half holds the inverse scaled per row; the host normalises. It sits between the host register interface and the inversion datapath.

Parameters:
N, 5, matrix order (rows); augmented array is N x 2N
W, 8, element width in bits; all arithmetic wraps modulo 2^W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe for the left half; ignored while busy=1
wr_row  in  $clog2(N)  write row index
wr_col  in  $clog2(N)  write column index, 0..N-1
wr_data  in  W  write element
start  in  1  single-cycle request; accepted only in IDLE
rd_row  in  $clog2(N)  readout row index
rd_col  in  $clog2(2N)  readout column index, 0..2N-1
rd_data  out  W  registered readout, valid 1 cycle after address
busy  out  1  high from the cycle after start is accepted until the DONE state
done  out  1  one-cycle pulse in DONE
singular  out  1  set in DONE when no pivot is found; held until the next accepted start

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, busy=0, done=0, singular=0, rd_data=0, whole array=0, all counters=0. Reset mid-operation aborts immediately; no partial done.
- IDLE: a host write sets mat[wr_row][wr_col] at the clock edge. start=1 causes a move to INIT and clears singular. start while busy is ignored.
- INIT (1 cycle): right half is set to identity (mat[i][N+i]=1, all others 0). p=0.
- PIV_CHK (1 cycle): latch piv=mat[p][p].
  - If piv!=0: r=first row !=p, go to ROW_SETUP.
  - Else: s=p+1, go to SEARCH. If p=N-1, go to DONE with singular=1.
- SEARCH (1 cycle per row examined):
  - If mat[s][p]!=0: c=0, go to SWAP.
  - Else if s=N-1: go to DONE with singular=1.
  - Else: s++.
- SWAP (2N cycles): exchange mat[p][c] and mat[s][c] at column c, c=0..2N-1. Then return to PIV_CHK.
- ROW_SETUP (1 cycle): latch f=mat[r][p]; c=0.
- ELIM (2N cycles): mat[r][c] <= low W bits of (mat[r][c]*piv - f*mat[p][c]).
  - Row p is never written during elimination.
  - Rows with f=0 are still processed, which scales them by piv.
  - After c=2N-1: advance r, skipping p. After the last row: p++. If p=N, go to DONE; else go to PIV_CHK.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Cycle count with no swaps: busy is high for 1 + N*(1 + (N-1)*(2N+1)) cycles, which is 226 for N=5.
- Each swap adds (rows searched) + 2N + 1 cycles.
- Readout: rd_data <= mat[rd_row][rd_col] every cycle. Valid at any time, but values change while busy.

Optional Feature:
- Macro INV_PERF_CNT_EN.
- Defined: adds output port cyc_count (16 bits).
  - Cleared on an accepted start.
  - Increments on every busy cycle and saturates at 0xFFFF.
  - Holds its value after done.
  - Reset value 0.
- Undefined: no port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Package inv_pkg holds:
  - the N and W defaults;
  - the state enum (IDLE, INIT, PIV_CHK, SEARCH, SWAP, ROW_SETUP, ELIM, DONE);
  - the index-width localparams;
  - an element typedef logic [W-1:0].
- One sub-module, inv_xmul: combinational a*b - c*d, truncated to W bits. It is instantiated once and shared by all ELIM cycles.

Test Plan:
- Identity: load I, start → left and right halves are both I, singular=0, busy for exactly 226 cycles, done pulse for 1 cycle.
- Row swap: load permutation rows (e1,e0,e2,e3,e4), start → 1 SEARCH + 10 SWAP cycles, busy for 238 cycles, left=I, right=the same permutation, singular=0.
- Singular: column 0 all zero → INIT, PIV_CHK, 4 SEARCH cycles, done with singular=1 after 6 busy cycles; singular holds until the next start.
- Wrap: diag(16,16,1,1,1) with W=8 → p=0 scales row1 so mat[1][1]=256 mod 256=0. SEARCH finds no pivot, singular=1 after 50 busy cycles.
- Robustness:
  - wr_en and start asserted mid-run are ignored; the array result matches the clean run.
  - rst_n pulsed low at cycle 100 of a run → busy=0 and the array is 0 at once; a fresh load and start completes normally.
- INV_PERF_CNT_EN: identity run → cyc_count=226; swap run → 238; the value holds after done.
